// File: rtl/sdcard_blkseq.sv
// rtl/sdcard_blkseq.sv - multi-block SD card read sequencer driving the PI1 slave port
// Optional overlap of the next CMDREAD with the drain: define SDCARD_BLKSEQ_PREFETCH_EN.
module sdcard_blkseq #(
    parameter int ARCHBITSZ = 32,
    parameter int CNTBITSZ  = 16,
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8),
    localparam int WORDS     = 512 / (ARCHBITSZ / 8),
    localparam int WBITS     = $clog2(WORDS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [ADDRBITSZ-1:0]     cmd_blk_i,
    input  logic [CNTBITSZ-1:0]      cmd_cnt_i,
    output logic [ARCHBITSZ-1:0]     dat_o,
    output logic                     dat_valid_o,
    input  logic                     dat_ready_i,
    output logic                     done_o,
    output logic                     err_o,
    output logic [1:0]               m_op_o,
    output logic [ADDRBITSZ-1:0]     m_addr_o,
    output logic [ARCHBITSZ-1:0]     m_data_o,
    input  logic [ARCHBITSZ-1:0]     m_data_i,
    output logic [ARCHBITSZ/8-1:0]   m_sel_o,
    input  logic                     m_rdy_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDCMD,
        S_POLL,
        S_SWAP,
`ifdef SDCARD_BLKSEQ_PREFETCH_EN
        S_PREF,
`endif
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDRBITSZ-1:0]   blk_q;
    logic [CNTBITSZ-1:0]    cnt_q;
    logic [WBITS-1:0]       w_q;
    logic                   resp_q;
    logic [ARCHBITSZ-1:0]   dat_q;
    logic                   dat_valid_q;
    logic                   err_q;

    logic handoff;
    logic last_word;
    assign handoff   = dat_valid_q & dat_ready_i;
    assign last_word = (w_q == WBITS'(WORDS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // resp_q marks the cycle after an accepted PI1 request, when m_data_i is valid
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid_i) state_d = (cmd_cnt_i == '0) ? S_DONE : S_RDCMD;
            S_RDCMD: if (resp_q) state_d = S_POLL;
            S_POLL: begin
                if (resp_q) begin
                    if (m_data_i == ARCHBITSZ'(1))      state_d = S_SWAP;
                    else if (m_data_i == ARCHBITSZ'(2)) state_d = S_POLL;
                    else                                state_d = S_ERR;
                end
            end
            S_SWAP: begin
                if (resp_q) begin
`ifdef SDCARD_BLKSEQ_PREFETCH_EN
                    state_d = (cnt_q != CNTBITSZ'(1)) ? S_PREF : S_DRAIN;
`else
                    state_d = S_DRAIN;
`endif
                end
            end
`ifdef SDCARD_BLKSEQ_PREFETCH_EN
            S_PREF:  if (resp_q) state_d = S_DRAIN;
`endif
            S_DRAIN: begin
                if (handoff && last_word) begin
                    if (cnt_q == '0) state_d = S_DONE;
`ifdef SDCARD_BLKSEQ_PREFETCH_EN
                    else             state_d = S_POLL;
`else
                    else             state_d = S_RDCMD;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_op_o   = 2'b00;
        m_addr_o = '0;
        m_data_o = '0;
        case (state_q)
`ifdef SDCARD_BLKSEQ_PREFETCH_EN
            S_RDCMD, S_PREF: begin
`else
            S_RDCMD: begin
`endif
                if (!resp_q) begin
                    m_op_o   = 2'b11;
                    m_addr_o = ADDRBITSZ'(2);
                    m_data_o = ARCHBITSZ'(blk_q);
                end
            end
            S_POLL: if (!resp_q) m_op_o = 2'b11;
            S_SWAP: begin
                if (!resp_q) begin
                    m_op_o   = 2'b11;
                    m_addr_o = ADDRBITSZ'(1);
                end
            end
            S_DRAIN: begin
                if (!resp_q && !dat_valid_q) begin
                    m_op_o   = 2'b10;
                    m_addr_o = ADDRBITSZ'(w_q);
                end
            end
            default: ;
        endcase
    end

    assign m_sel_o     = {(ARCHBITSZ/8){m_op_o != 2'b00}};
    assign cmd_ready_o = (state_q == S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;
    assign dat_o       = dat_q;
    assign dat_valid_o = dat_valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_q       <= '0;
            cnt_q       <= '0;
            w_q         <= '0;
            resp_q      <= 1'b0;
            dat_q       <= '0;
            dat_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            resp_q <= (m_op_o != 2'b00) && m_rdy_i;
            if (state_q == S_IDLE && cmd_valid_i) begin
                blk_q <= cmd_blk_i;
                cnt_q <= cmd_cnt_i;
                err_q <= 1'b0;
            end
            if (state_d == S_ERR) err_q <= 1'b1;
            // blk advances at SWAP so a following CMDREAD already targets the next block
            if (state_q == S_SWAP && resp_q) begin
                cnt_q <= cnt_q - 1'b1;
                blk_q <= blk_q + 1'b1;
            end
            if (state_q != S_DRAIN)        w_q <= '0;
            else if (handoff && !last_word) w_q <= w_q + 1'b1;
            if (state_q == S_DRAIN && resp_q) begin
                dat_q       <= m_data_i;
                dat_valid_q <= 1'b1;
            end else if (handoff) begin
                dat_valid_q <= 1'b0;
            end
        end
    end

endmodule
